// File: rtl/mem_copy_dma.sv
// Word-granular memory-to-memory copy engine: MMIO-programmed, alternates one read and
// one write on the initiator bus per word until LEN words are copied or an abort is taken.
module mem_copy_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        irq_done
);

    localparam logic [7:0] ADDR_CTRL      = 8'h10;
    localparam logic [7:0] ADDR_STATUS    = 8'h11;
    localparam logic [7:0] ADDR_SRC       = 8'h20;
    localparam logic [7:0] ADDR_DST       = 8'h21;
    localparam logic [7:0] ADDR_LEN       = 8'h22;
    localparam logic [7:0] ADDR_REMAINING = 8'h23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [31:0]          src_reg, src_next;
    logic [31:0]          dst_reg, dst_next;
    logic [LEN_WIDTH-1:0] len_reg, len_next;
    logic [LEN_WIDTH-1:0] remaining_reg, remaining_next;
    logic [31:0]          src_cur_reg, src_cur_next;
    logic [31:0]          dst_cur_reg, dst_cur_next;
    logic [31:0]          data_reg, data_next;
    logic                 done_reg, done_next;
    logic                 aborted_reg, aborted_next;
    logic                 abort_pend_reg, abort_pend_next;
    logic                 mem_valid_reg, mem_valid_next;
    logic [31:0]          mem_addr_reg, mem_addr_next;
    logic [31:0]          mem_wdata_reg, mem_wdata_next;
    logic [3:0]           mem_wstrb_reg, mem_wstrb_next;
    logic                 ready_reg;
    logic [31:0]          read_data_reg, read_data_next;

    logic busy;
    logic cfg_wr;
    logic ctrl_wr;
    logic start_req;
    logic abort_req;
    logic abort_now;

    assign busy      = (state_reg != ST_IDLE);
    assign cfg_wr    = cs && we && !busy;
    assign ctrl_wr   = cs && we && (address == ADDR_CTRL);
    assign start_req = ctrl_wr && write_data[0];
    assign abort_req = ctrl_wr && write_data[1];
    // An abort arriving on the same edge as the completion is honoured immediately.
    assign abort_now = abort_pend_reg || abort_req;

    // MMIO readback, captured on the access edge so it pairs with the delayed ready.
    always_comb begin
        read_data_next = 32'h0;
        if (cs && !we) begin
            case (address)
                ADDR_STATUS:    read_data_next = {29'h0, aborted_reg, done_reg, busy};
                ADDR_SRC:       read_data_next = src_reg;
                ADDR_DST:       read_data_next = dst_reg;
                ADDR_LEN:       read_data_next = 32'(len_reg);
                ADDR_REMAINING: read_data_next = 32'(remaining_reg);
                default:        read_data_next = 32'h0;
            endcase
        end
    end

    // Next-state and registered bus outputs are computed together so the bus sees the
    // new address on the cycle right after a completion.
    always_comb begin
        state_next      = state_reg;
        src_next        = src_reg;
        dst_next        = dst_reg;
        len_next        = len_reg;
        remaining_next  = remaining_reg;
        src_cur_next    = src_cur_reg;
        dst_cur_next    = dst_cur_reg;
        data_next       = data_reg;
        done_next       = done_reg;
        aborted_next    = aborted_reg;
        abort_pend_next = abort_pend_reg;
        mem_valid_next  = mem_valid_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_wstrb_next  = mem_wstrb_reg;

        if (cfg_wr) begin
            case (address)
                ADDR_SRC: src_next = {write_data[31:2], 2'b00};
                ADDR_DST: dst_next = {write_data[31:2], 2'b00};
                ADDR_LEN: len_next = write_data[LEN_WIDTH-1:0];
                default:  ;
            endcase
        end

        case (state_reg)
            ST_IDLE: begin
                if (start_req) begin
                    aborted_next   = 1'b0;
                    src_cur_next   = src_reg;
                    dst_cur_next   = dst_reg;
                    remaining_next = len_reg;
                    if (len_reg == '0) begin
                        done_next = 1'b1;
                    end else begin
                        done_next      = 1'b0;
                        state_next     = ST_RD;
                        mem_valid_next = 1'b1;
                        mem_addr_next  = src_reg;
                        mem_wstrb_next = 4'h0;
                    end
                end
            end

            ST_RD: begin
                if (abort_req) abort_pend_next = 1'b1;
                if (mem_ready) begin
                    if (abort_now) begin
                        state_next      = ST_IDLE;
                        aborted_next    = 1'b1;
                        done_next       = 1'b0;
                        abort_pend_next = 1'b0;
                        mem_valid_next  = 1'b0;
                        mem_wstrb_next  = 4'h0;
                    end else begin
                        data_next      = mem_rdata;
                        state_next     = ST_WR;
                        mem_addr_next  = dst_cur_reg;
                        mem_wdata_next = mem_rdata;
                        mem_wstrb_next = 4'hf;
                    end
                end
            end

            ST_WR: begin
                if (abort_req) abort_pend_next = 1'b1;
                if (mem_ready) begin
                    if (abort_now) begin
                        state_next      = ST_IDLE;
                        aborted_next    = 1'b1;
                        done_next       = 1'b0;
                        abort_pend_next = 1'b0;
                        mem_valid_next  = 1'b0;
                        mem_wstrb_next  = 4'h0;
                    end else begin
                        src_cur_next   = src_cur_reg + 32'd4;
                        dst_cur_next   = dst_cur_reg + 32'd4;
                        remaining_next = remaining_reg - 1'b1;
                        if (remaining_reg == LEN_WIDTH'(1)) begin
                            state_next     = ST_IDLE;
                            done_next      = 1'b1;
                            mem_valid_next = 1'b0;
                            mem_wstrb_next = 4'h0;
                        end else begin
                            state_next     = ST_RD;
                            mem_addr_next  = src_cur_reg + 32'd4;
                            mem_wstrb_next = 4'h0;
                        end
                    end
                end
            end

            default: begin
                state_next     = ST_IDLE;
                mem_valid_next = 1'b0;
                mem_wstrb_next = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            src_reg        <= 32'h0;
            dst_reg        <= 32'h0;
            len_reg        <= '0;
            remaining_reg  <= '0;
            src_cur_reg    <= 32'h0;
            dst_cur_reg    <= 32'h0;
            data_reg       <= 32'h0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
            abort_pend_reg <= 1'b0;
            mem_valid_reg  <= 1'b0;
            mem_addr_reg   <= 32'h0;
            mem_wdata_reg  <= 32'h0;
            mem_wstrb_reg  <= 4'h0;
            ready_reg      <= 1'b0;
            read_data_reg  <= 32'h0;
        end else begin
            state_reg      <= state_next;
            src_reg        <= src_next;
            dst_reg        <= dst_next;
            len_reg        <= len_next;
            remaining_reg  <= remaining_next;
            src_cur_reg    <= src_cur_next;
            dst_cur_reg    <= dst_cur_next;
            data_reg       <= data_next;
            done_reg       <= done_next;
            aborted_reg    <= aborted_next;
            abort_pend_reg <= abort_pend_next;
            mem_valid_reg  <= mem_valid_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_wstrb_reg  <= mem_wstrb_next;
            ready_reg      <= cs;
            read_data_reg  <= read_data_next;
        end
    end

    assign read_data = read_data_reg;
    assign ready     = ready_reg;
    assign mem_valid = mem_valid_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_wstrb = mem_wstrb_reg;
    assign irq_done  = done_reg;

endmodule

// File: doc/mem_copy_dma.md
Name: mem_copy_dma

Overview:
Word-granular memory-to-memory copy engine that acts as a bus initiator toward the CPU-side memory interconnect. It uses the same valid/ready/addr/wdata/wstrb/rdata protocol the CPU issues. Firmware configures it through a standard MMIO core interface (cs/we/address/write_data/read_data/ready). It then alternates read and write transactions until the programmed word count is copied or an abort is taken.

Parameters:
LEN_WIDTH, 16, width of LEN and REMAINING word counters (max transfer 2^LEN_WIDTH-1 words)

Ports:
clk  in  1  system clock
reset_n  in  1  reset, asynchronous, active-low
cs  in  1  MMIO core select
we  in  1  MMIO write enable
address  in  8  MMIO word address
write_data  in  32  MMIO write data
read_data  out  32  MMIO read data, valid when ready=1
ready  out  1  MMIO access complete
mem_valid  out  1  initiator request valid
mem_addr  out  32  initiator word-aligned address
mem_wdata  out  32  initiator write data
mem_wstrb  out  4  4'h0 read, 4'hf write
mem_ready  in  1  responder completion
mem_rdata  in  32  responder read data, sampled when mem_ready=1
irq_done  out  1  level: STATUS.done

Behaviour:
- Reset (clk and reset_n as named; reset asynchronous, active-low): all regs 0, FSM IDLE. Outputs mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, ready=0, read_data=0, irq_done=0. Asserting reset mid-transfer drops mem_valid immediately, with no completion.
- MMIO: ready is registered and equals cs delayed 1 cycle. read_data is registered in the same cycle. Register map:
  - 0x10 CTRL (W): bit0 start, bit1 abort. Reads return 0.
  - 0x11 STATUS (R): bit0 busy, bit1 done, bit2 aborted.
  - 0x20 SRC (RW).
  - 0x21 DST (RW).
  - 0x22 LEN (RW, LEN_WIDTH bits, zero-extended).
  - 0x23 REMAINING (R).
  - Any other address reads 0; writes to it are ignored.
- SRC/DST bits[1:0] are ignored; internal addresses are always {x[31:2],2'b00}.
- Writes to SRC/DST/LEN while busy are ignored.
- Start:
  - Start while busy: ignored.
  - Start while idle: clears done and aborted, loads src_cur=SRC, dst_cur=DST, REMAINING=LEN.
  - If LEN=0: done=1 next cycle; no bus transaction is issued.
  - Otherwise: go to RD.
- FSM states: IDLE, RD, WR.
  - RD: mem_valid=1, mem_addr=src_cur, mem_wstrb=0. On a clk edge with mem_ready=1: data_reg<=mem_rdata, go to WR.
  - WR: mem_valid=1, mem_addr=dst_cur, mem_wdata=data_reg, mem_wstrb=4'hf. On mem_ready=1: src_cur+=4, dst_cur+=4, REMAINING-=1. If REMAINING was 1, go to IDLE with done=1; else go to RD.
- Bus rules:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are registered outputs.
  - They stay stable while mem_valid=1 and mem_ready=0.
  - Back-to-back transactions have no idle cycle. The cycle after mem_ready, mem_valid stays high with the next address.
  - mem_valid falls the cycle after the final write's mem_ready.
  - mem_ready while mem_valid=0 is ignored.
- Address arithmetic is mod 2^32: 0xFFFF_FFFC+4 = 0x0000_0000.
- Abort:
  - Abort while idle: ignored.
  - Abort while busy sets a pending flag. The outstanding transaction is never cut short.
  - On the next mem_ready (RD or WR), the FSM goes to IDLE with aborted=1, done=0, and REMAINING holding its current value. An aborted RD does not issue its WR.
  - Start and abort in the same write: abort wins if busy; start wins if idle.
- Busy = (state != IDLE). irq_done = done. done clears only on the next start or on reset.
- Throughput with a 1-cycle responder: 2 cycles per word after the first.

Test Plan:
- Reset check: assert reset_n=0 asynchronously mid-cycle -> all outputs 0 immediately; STATUS reads 0x0 after release.
- Basic copy: SRC=0x4000_0000, DST=0x4000_1000, LEN=3; responder gives mem_ready 1 cycle after valid and rdata=0xA0+n -> bus sequence is R 0x4000_0000, W 0x4000_1000/0xA0, R …04, W …1004, R …08, W …1008. Then done=1, irq_done=1, REMAINING=0, STATUS=0x2.
- LEN=0 start -> mem_valid never asserts; STATUS=0x2 two cycles after the CTRL write.
- Abort mid-read: responder stalls 5 cycles; abort issued during the first RD -> mem_valid and mem_addr stay stable until mem_ready. No write follows; STATUS=0x4, REMAINING=LEN.
- Busy protection: during transfer, write SRC=0xDEAD_BEEF and a second start -> SRC readback is unchanged and the transfer completes with the original parameters.
- Wrap and alignment: SRC=0xFFFF_FFFE, DST=0x10, LEN=2 -> reads at 0xFFFF_FFFC then 0x0000_0000; writes at 0x10 and 0x14.
